adc_ad7476_seq_ctrl: RTL and testbench
======================================

// Module: adc_ad7476_seq_ctrl
// PURPOSE
//  Master-side sequencer for one AD7476A-class serial ADC (CS_n/SCLK/SDATA, 16-bit frame, 4 leading zeros + 12 data, MSB first).
//  Schedules conversions periodically or on a one-shot trigger, drives the SPI frame, captures SDATA on SCLK rising edges and
//  hands the 12-bit result to the fabric via a valid/ready holding register. Sits between the pad-level ADC pins and the sample FIFO.
// PARAMETERS
//  CLK_DIV       4    clk_i cycles per SCLK half-period; legal range 2..255
//  QUIET_CYCLES  2    clk_i cycles that CS_n is held high after each frame before the next may start; legal range 1..255
//  PERIOD_W      16   width of period_i
// PORTS
//  clk_i           in   1         system clock; all logic on the rising edge
//  rst_i           in   1         synchronous, active-high reset
//  enable_i        in   1         1 = periodic conversions every period_i clocks
//  single_i        in   1         1-cycle pulse: request one conversion (honoured only while enable_i=0)
//  period_i        in   PERIOD_W  conversion start-to-start interval in clk_i cycles; sampled at each frame start
//  cs_n_o          out  1         ADC chip select, active low
//  sclk_o          out  1         ADC serial clock, idles high
//  sdata_i         in   1         ADC serial data
//  sample_o        out  12        last captured conversion result (frame bits [11:0])
//  sample_valid_o  out  1         sample_o holds an unconsumed result
//  sample_ready_i  in   1         consumer accepts sample_o when valid & ready
//  lead_err_o      out  1         sticky: a frame had a nonzero bit in [15:12]
//  overrun_o       out  1         sticky: a frame completed while sample_valid_o=1 (new result dropped)
//  clr_status_i    in   1         1-cycle pulse clears lead_err_o and overrun_o
//  busy_o          out  1         1 while state != IDLE
// BEHAVIOUR
//  Reset values: cs_n_o=1, sclk_o=1, sample_o=0, sample_valid_o=0, lead_err_o=0, overrun_o=0, busy_o=0, state=IDLE, counters=0.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> QUIET -> IDLE.
//   IDLE : start when (enable_i & period counter expired) or (!enable_i & single_i). Period counter loads period_i at each
//          start and decrements to 0. Counter initialises expired, so the first frame starts 1 cycle after enable_i rises.
//   SETUP: cs_n_o=0, sclk_o=1 for CLK_DIV cycles (ADC drives bit 15 on CS_n fall).
//   SHIFT: 16 SCLK periods; sclk_o goes low for CLK_DIV, then high for CLK_DIV. sdata_i is shifted into a 16-bit register
//          (MSB first) on the clk_i edge where sclk_o goes 0->1. Exit after the 16th rising edge.
//   HOLD : cs_n_o stays 0, sclk_o=1 for CLK_DIV cycles; then cs_n_o->1. Result commit happens on HOLD exit.
//   QUIET: cs_n_o=1 for QUIET_CYCLES, then IDLE.
//  Frame length = CLK_DIV*(2+32) + QUIET_CYCLES clocks. If period_i is smaller, frames run back-to-back (no pending queue, no error).
//  Commit: if sample_valid_o=0 or sample_ready_i=1 that cycle, load sample_o=rx[11:0] and set valid; otherwise drop and set overrun_o.
//   lead_err_o set if rx[15:12]!=0 (also when dropped). valid clears on valid&ready without a same-cycle commit.
//  Same-cycle set and clr_status_i: set wins.
//  enable_i falling mid-frame: frame completes normally, then IDLE. single_i while busy or while enable_i=1: ignored.
//  rst_i mid-frame: next edge forces reset values (cs_n_o=1, sclk_o=1); partial frame discarded.
//  All outputs registered; no combinational input->output path.
// STRUCTURE
//  Package adc_ad7476_pkg: FSM state encoding, FRAME_BITS=16, LEAD_BITS=4, DATA_BITS=12, SCLK_IDLE=1'b1.
//  Sub-module adc_ad7476_spi_shifter: SCLK half-period divider, bit counter, shift register, done pulse.
//  Top: scheduler/period counter, FSM, result holding register, sticky flags.
// TESTING (bench uses the team's AD7476A SPI slave model; its samples are 0x0AA5, 0x0AA6, ...)
//  1 rst_i, CLK_DIV=4, enable_i=0, single_i pulse -> one 16-SCLK frame; cs_n_o low 136 clocks; sample_o=0xAA5, valid=1.
//  2 enable_i=1, period_i=200, sample_ready_i=1 -> CS_n falls every 200 clocks; results 0xAA5, 0xAA6, 0xAA7.
//  3 period_i=10 (< frame 138) -> back-to-back frames with exactly QUIET_CYCLES=2 of CS_n high between them.
//  4 sample_ready_i=0 for two frames -> sample_o stays 0xAA5, overrun_o=1; clr_status_i -> overrun_o=0.
//  5 slave model forced to 0xF123 -> sample_o=0x123, lead_err_o=1.
//  6 rst_i asserted mid-SHIFT -> next cycle cs_n_o=1, sclk_o=1, valid=0; next single_i gives a clean frame.

Source files
------------

// File: rtl/adc_ad7476_pkg.sv
// adc_ad7476_pkg: shared frame geometry and sequencer state encoding for the AD7476A controller
package adc_ad7476_pkg;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS = 4;
  localparam int DATA_BITS = 12;
  localparam logic SCLK_IDLE = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_QUIET} state_t;
endpackage

// File: rtl/adc_ad7476_spi_shifter.sv
// adc_ad7476_spi_shifter: SCLK half-period divider, 16-bit MSB-first capture on SCLK rising edges, done pulse
module adc_ad7476_spi_shifter
  import adc_ad7476_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  sdata_i,
  output logic                  sclk_o,
  output logic [FRAME_BITS-1:0] rx_o,
  output logic                  done_o
);
  localparam int HW = $clog2(2 * FRAME_BITS);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * FRAME_BITS - 1);
  logic [7:0] r_div;
  logic [HW-1:0] r_half;
  logic r_active;
  logic r_sclk;
  logic [FRAME_BITS-1:0] r_rx;
  logic w_tick;
  assign w_tick = r_active && r_div == DIV_M1;
  assign done_o = w_tick && r_half == HALF_LAST;
  assign sclk_o = r_sclk;
  assign rx_o = r_rx;
  // Even halves are SCLK low, odd halves high; the final half ends with SCLK parked at idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active <= 1'b0;
      r_div <= '0;
      r_half <= '0;
      r_sclk <= SCLK_IDLE;
      r_rx <= '0;
    end else if (start_i) begin
      r_active <= 1'b1;
      r_div <= '0;
      r_half <= '0;
      r_sclk <= ~SCLK_IDLE;
    end else if (w_tick) begin
      r_div <= '0;
      r_half <= r_half + HW'(1);
      r_sclk <= ~r_sclk | done_o;
      r_active <= ~done_o;
      if (!r_sclk) r_rx <= {r_rx[FRAME_BITS-2:0], sdata_i};
    end else if (r_active) begin
      r_div <= r_div + 8'd1;
    end
  end
endmodule

// File: rtl/adc_ad7476_seq_ctrl.sv
// adc_ad7476_seq_ctrl: conversion scheduler, CS_n framing FSM, result holding register and sticky status for one AD7476A
module adc_ad7476_seq_ctrl
  import adc_ad7476_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int QUIET_CYCLES = 2,
  parameter int PERIOD_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 single_i,
  input  logic [PERIOD_W-1:0]  period_i,
  output logic                 cs_n_o,
  output logic                 sclk_o,
  input  logic                 sdata_i,
  output logic [DATA_BITS-1:0] sample_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic                 lead_err_o,
  output logic                 overrun_o,
  input  logic                 clr_status_i,
  output logic                 busy_o
);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_M1 = 8'(QUIET_CYCLES - 1);
  state_t r_state;
  logic [7:0] r_cnt;
  logic [PERIOD_W-1:0] r_per;
  logic r_cs_n, r_busy, r_valid, r_lead, r_ovr;
  logic [DATA_BITS-1:0] r_sample;
  logic w_expired, w_req, w_quiet_end, w_go, w_shift_start, w_commit, w_done;
  logic [FRAME_BITS-1:0] w_rx;
  assign w_expired = r_per <= PERIOD_W'(1);
  assign w_req = enable_i ? w_expired : single_i;
  assign w_quiet_end = r_state == ST_QUIET && r_cnt == QUIET_M1;
  // Periodic mode may restart straight out of QUIET so back-to-back frames keep exactly QUIET_CYCLES of CS_n high
  assign w_go = (r_state == ST_IDLE && w_req) || (w_quiet_end && enable_i && w_expired);
  assign w_shift_start = r_state == ST_SETUP && r_cnt == DIV_M1;
  assign w_commit = r_state == ST_HOLD && r_cnt == DIV_M1;
  assign cs_n_o = r_cs_n;
  assign busy_o = r_busy;
  assign sample_o = r_sample;
  assign sample_valid_o = r_valid;
  assign lead_err_o = r_lead;
  assign overrun_o = r_ovr;
  adc_ad7476_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(w_shift_start),
    .sdata_i(sdata_i),
    .sclk_o (sclk_o),
    .rx_o   (w_rx),
    .done_o (w_done)
  );
  // Frame sequencing, period countdown and registered CS_n/busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_per <= '0;
      r_cs_n <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_per <= w_go ? period_i : (r_per != '0 ? r_per - PERIOD_W'(1) : r_per);
      r_cnt <= (w_go || w_shift_start || w_commit || r_state == ST_IDLE || r_state == ST_SHIFT) ? '0 : r_cnt + 8'd1;
      if (w_go) begin
        r_state <= ST_SETUP;
        r_cs_n <= 1'b0;
        r_busy <= 1'b1;
      end else begin
        case (r_state)
          ST_SETUP: if (w_shift_start) r_state <= ST_SHIFT;
          ST_SHIFT: if (w_done) r_state <= ST_HOLD;
          ST_HOLD: if (w_commit) begin
            r_state <= ST_QUIET;
            r_cs_n <= 1'b1;
          end
          ST_QUIET: if (w_quiet_end) begin
            r_state <= ST_IDLE;
            r_busy <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
  // Result hand-off at frame end; sticky flags give priority to a new event over clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sample <= '0;
      r_valid <= 1'b0;
      r_lead <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_commit && (!r_valid || sample_ready_i)) begin
        r_sample <= w_rx[DATA_BITS-1:0];
        r_valid <= 1'b1;
      end else if (r_valid && sample_ready_i) begin
        r_valid <= 1'b0;
      end
      r_ovr <= (w_commit && r_valid && !sample_ready_i) || (r_ovr && !clr_status_i);
      r_lead <= (w_commit && w_rx[FRAME_BITS-1 -: LEAD_BITS] != '0) || (r_lead && !clr_status_i);
    end
  end
endmodule

// File: tb/tb_adc_ad7476_seq_ctrl.sv
// tb_adc_ad7476_seq_ctrl: directed checks of the AD7476A sequencer against a behavioural ADC slave
module tb_adc_ad7476_seq_ctrl;
  localparam int LIM = 1000;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, single = 1'b0, ready = 1'b0, clr = 1'b0, sdata = 1'b0;
  logic [15:0] period = 16'd200;
  logic cs_n, sclk, valid, lead, ovr, busy;
  logic [11:0] sample;
  logic [15:0] nxt = 16'h0AA5, word = 16'h0;
  int k = 0, cyc = 0, vectors = 0, miscompares = 0;
  int gap, low, rises, t0, t1;
  always #5 clk = ~clk;
  // free-running cycle stamp for start-to-start measurements
  always @(posedge clk) cyc <= cyc + 1;
  adc_ad7476_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .single_i(single), .period_i(period),
    .cs_n_o(cs_n), .sclk_o(sclk), .sdata_i(sdata), .sample_o(sample), .sample_valid_o(valid),
    .sample_ready_i(ready), .lead_err_o(lead), .overrun_o(ovr), .clr_status_i(clr), .busy_o(busy)
  );
  // ADC slave: bit 15 appears on CS_n fall, each later bit after the SCLK rising edge that captured the previous one
  always @(negedge cs_n) begin
    word = nxt;
    nxt = nxt + 16'd1;
    k = 0;
    sdata = word[15];
  end
  // advance the slave to the next bit after each capture edge
  always @(posedge sclk) if (cs_n === 1'b0) begin
    #1;
    k++;
    if (k < 16) sdata = word[15-k];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_single();
    @(negedge clk) single = 1'b1;
    @(negedge clk) single = 1'b0;
  endtask
  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < LIM), 32'd1);
  endtask
  task automatic run_frame(output int g, output int l, output int r, output int t);
    logic p;
    g = 0;
    l = 0;
    r = 0;
    while (cs_n !== 1'b0 && g < LIM) begin
      @(negedge clk);
      g++;
    end
    chk("cs_fall_timeout", 32'(g < LIM), 32'd1);
    t = cyc;
    while (cs_n === 1'b0 && l < LIM) begin
      p = sclk;
      @(negedge clk);
      l++;
      if (!p && sclk === 1'b1) r++;
    end
    chk("cs_rise_timeout", 32'(l < LIM), 32'd1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {30'd0, lead, ovr}, 32'd0);
    rst = 1'b0;
    nxt = 16'h0AA5;
    pulse_single();
    run_frame(gap, low, rises, t0);
    chk("t1_cs_low", 32'(low), 32'd136);
    chk("t1_sclk_rises", 32'(rises), 32'd16);
    chk("t1_sample", 32'(sample), 32'h0AA5);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_busy_quiet", 32'(busy), 32'd1);
    chk("t1_lead", 32'(lead), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    nxt = 16'h0AA5;
    ready = 1'b1;
    period = 16'd200;
    @(negedge clk) enable = 1'b1;
    run_frame(gap, low, rises, t0);
    chk("t2_sample0", 32'(sample), 32'h0AA5);
    chk("t2_valid0", 32'(valid), 32'd1);
    run_frame(gap, low, rises, t1);
    chk("t2_period1", 32'(t1 - t0), 32'd200);
    chk("t2_sample1", 32'(sample), 32'h0AA6);
    t0 = t1;
    run_frame(gap, low, rises, t1);
    chk("t2_period2", 32'(t1 - t0), 32'd200);
    chk("t2_sample2", 32'(sample), 32'h0AA7);
    period = 16'd10;
    t0 = t1;
    run_frame(gap, low, rises, t1);
    chk("t3_period_old", 32'(t1 - t0), 32'd200);
    chk("t3_sample3", 32'(sample), 32'h0AA8);
    t0 = t1;
    run_frame(gap, low, rises, t1);
    enable = 1'b0;
    chk("t3_quiet_gap", 32'(gap), 32'd2);
    chk("t3_b2b_period", 32'(t1 - t0), 32'd138);
    chk("t3_cs_low", 32'(low), 32'd136);
    chk("t3_sample4", 32'(sample), 32'h0AA9);
    wait_idle();
    ready = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    nxt = 16'h0AA5;
    pulse_single();
    run_frame(gap, low, rises, t0);
    chk("t4_sample_a", 32'(sample), 32'h0AA5);
    chk("t4_ovr_a", 32'(ovr), 32'd0);
    wait_idle();
    pulse_single();
    run_frame(gap, low, rises, t0);
    chk("t4_sample_held", 32'(sample), 32'h0AA5);
    chk("t4_valid_held", 32'(valid), 32'd1);
    chk("t4_overrun", 32'(ovr), 32'd1);
    wait_idle();
    pulse_clr();
    chk("t4_ovr_cleared", 32'(ovr), 32'd0);
    chk("t4_valid_kept", 32'(valid), 32'd1);
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    chk("t4_consumed", 32'(valid), 32'd0);
    nxt = 16'hF123;
    pulse_single();
    run_frame(gap, low, rises, t0);
    chk("t5_sample", 32'(sample), 32'h0123);
    chk("t5_lead_err", 32'(lead), 32'd1);
    chk("t5_ovr", 32'(ovr), 32'd0);
    wait_idle();
    pulse_clr();
    chk("t5_lead_cleared", 32'(lead), 32'd0);
    nxt = 16'h0ABC;
    pulse_single();
    gap = 0;
    while (sclk !== 1'b0 && gap < LIM) begin
      @(negedge clk);
      gap++;
    end
    chk("t6_in_shift", {cs_n, sclk}, 32'd0);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("t6_rst_cs_n", 32'(cs_n), 32'd1);
    chk("t6_rst_sclk", 32'(sclk), 32'd1);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    nxt = 16'h0ABC;
    pulse_single();
    run_frame(gap, low, rises, t0);
    chk("t6_cs_low", 32'(low), 32'd136);
    chk("t6_sclk_rises", 32'(rises), 32'd16);
    chk("t6_sample", 32'(sample), 32'h0ABC);
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_lead", 32'(lead), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
